// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - issue/writeback/query bundle between decode and hazard scoreboard
//
// Purpose: groups the decode-facing signals of the hazard scoreboard.
// Ports (as seen by the scoreboard, slave modport):
//   issue_valid, issue_rd[4:0], issue_wen, issue_csr  in   instruction issuing this cycle
//   wb_valid, wb_rd[4:0], wb_csr                      in   writes retiring this cycle
//   flush                                             in   discard all in-flight writes
//   rs1[4:0], rs2[4:0]                                in   source GPRs of decode instruction
//   bubble1, bubble2, bubble3                         out  rs1 / rs2 / CSR hazard
//   issue_ready, pending_any, err_underflow           out  issue accept, any in flight, sticky error
interface hazard_scoreboard_if;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic       issue_wen;
    logic       issue_csr;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       wb_csr;
    logic       flush;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       bubble1;
    logic       bubble2;
    logic       bubble3;
    logic       issue_ready;
    logic       pending_any;
    logic       err_underflow;

    modport master (
        output issue_valid, issue_rd, issue_wen, issue_csr,
        output wb_valid, wb_rd, wb_csr, flush, rs1, rs2,
        input  bubble1, bubble2, bubble3, issue_ready, pending_any, err_underflow
    );

    modport slave (
        input  issue_valid, issue_rd, issue_wen, issue_csr,
        input  wb_valid, wb_rd, wb_csr, flush, rs1, rs2,
        output bubble1, bubble2, bubble3, issue_ready, pending_any, err_underflow
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-GPR and CSR pending-write counters producing decode hazard bubbles
//
// Purpose: tracks in-flight register writes (up to MAXP per GPR x1..x31 and for the CSR
// file), flags read-after-write hazards for the decode stage with same-cycle writeback
// bypass, and back-pressures issue when a target counter is saturated.
// Ports:
//   clk    in  single clock, rising edge
//   reset  in  synchronous, active-low
//   sb     hazard_scoreboard_if.slave (see interface file for signal list)
module hazard_scoreboard #(
    parameter int MAXP = 3
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave sb
);
    localparam int CW = $clog2(MAXP + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAXP);
    localparam logic [CW-1:0] ONE  = CW'(1);

    // Entry 0 exists only so rd/rs indices need no range guard; it is held at zero.
    logic [CW-1:0] cnt [32];
    logic [CW-1:0] csr_cnt;
    logic          err_q;

    logic          gpr_full, csr_full, ready, fire;
    logic          gpr_inc, csr_inc, wb_hit1, wb_hit2, any;
    logic [31:0]   inc_vec, ret_vec;

    always_comb begin
        // A saturated target may still accept when its own retire frees a slot this cycle.
        gpr_full = sb.issue_wen && (sb.issue_rd != 5'd0) && (cnt[sb.issue_rd] == CMAX)
                   && !(sb.wb_valid && (sb.wb_rd == sb.issue_rd));
        csr_full = sb.issue_csr && (csr_cnt == CMAX) && !sb.wb_csr;
        ready    = !(gpr_full || csr_full);
        fire     = sb.issue_valid && ready && !sb.flush;
        gpr_inc  = fire && sb.issue_wen && (sb.issue_rd != 5'd0);
        csr_inc  = fire && sb.issue_csr;

        inc_vec = '0;
        ret_vec = '0;
        for (int r = 1; r < 32; r++) begin
            inc_vec[r] = gpr_inc && (sb.issue_rd == 5'(r));
            ret_vec[r] = sb.wb_valid && (sb.wb_rd == 5'(r));
        end

        wb_hit1 = sb.wb_valid && (sb.wb_rd == sb.rs1);
        wb_hit2 = sb.wb_valid && (sb.wb_rd == sb.rs2);

        any = (csr_cnt != '0);
        for (int r = 1; r < 32; r++) begin
            any = any || (cnt[r] != '0);
        end
    end

    // cnt - hit > 0 is the same as cnt > hit, which avoids an underflowing subtraction.
    assign sb.bubble1       = (sb.rs1 != 5'd0) && (cnt[sb.rs1] > (wb_hit1 ? ONE : '0));
    assign sb.bubble2       = (sb.rs2 != 5'd0) && (cnt[sb.rs2] > (wb_hit2 ? ONE : '0));
    assign sb.bubble3       = csr_cnt > (sb.wb_csr ? ONE : '0);
    assign sb.issue_ready   = ready;
    assign sb.pending_any   = any;
    assign sb.err_underflow = err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
            csr_cnt <= '0;
            err_q   <= 1'b0;
        end else if (sb.flush) begin
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
            csr_cnt <= '0;
        end else begin
            // Issue and retire hitting the same counter cancel out and leave it unchanged.
            for (int r = 1; r < 32; r++) begin
                if (inc_vec[r] && !ret_vec[r] && (cnt[r] != CMAX))
                    cnt[r] <= cnt[r] + ONE;
                else if (ret_vec[r] && !inc_vec[r] && (cnt[r] != '0))
                    cnt[r] <= cnt[r] - ONE;
            end
            if (csr_inc && !sb.wb_csr && (csr_cnt != CMAX))
                csr_cnt <= csr_cnt + ONE;
            else if (sb.wb_csr && !csr_inc && (csr_cnt != '0))
                csr_cnt <= csr_cnt - ONE;

            if ((sb.wb_valid && (sb.wb_rd != 5'd0) && (cnt[sb.wb_rd] == '0)) ||
                (sb.wb_csr && (csr_cnt == '0)))
                err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard with reference model
module tb_hazard_scoreboard;
    localparam int MAXP = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_scoreboard_if sb();
    hazard_scoreboard #(.MAXP(MAXP)) dut (.clk(clk), .reset(reset), .sb(sb));

    typedef struct packed {
        logic b1, b2, b3, rdy, pend, err;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: pending write counts as plain integers.
    int m_cnt [32];
    int m_csr;
    bit m_err;

    task automatic model_clear();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_csr = 0;
    endtask

    task automatic cmp(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive, predict outputs, advance model across the edge.
    task automatic step(input bit rst_n, input bit iv, input int ird, input bit iwen,
                        input bit icsr, input bit wv, input int wrd, input bit wcsr,
                        input bit fl, input int r1, input int r2);
        exp_t e;
        bit   gfull, cfull, rdy, fire, ig, ic, rg;
        reset = rst_n;
        sb.issue_valid = iv;   sb.issue_rd = 5'(ird); sb.issue_wen = iwen; sb.issue_csr = icsr;
        sb.wb_valid    = wv;   sb.wb_rd    = 5'(wrd); sb.wb_csr    = wcsr;
        sb.flush       = fl;   sb.rs1      = 5'(r1);  sb.rs2       = 5'(r2);

        e.b1  = (r1 != 0) && (m_cnt[r1] - ((wv && wrd == r1) ? 1 : 0) > 0);
        e.b2  = (r2 != 0) && (m_cnt[r2] - ((wv && wrd == r2) ? 1 : 0) > 0);
        e.b3  = (m_csr - (wcsr ? 1 : 0)) > 0;
        gfull = iwen && ird != 0 && m_cnt[ird] == MAXP && !(wv && wrd == ird);
        cfull = icsr && m_csr == MAXP && !wcsr;
        rdy   = !(gfull || cfull);
        e.rdy = rdy;
        e.pend = (m_csr != 0);
        for (int r = 1; r < 32; r++) if (m_cnt[r] != 0) e.pend = 1'b1;
        e.err = m_err;
        q.push_back(e);

        @(posedge clk);
        if (!rst_n) begin
            model_clear();
            m_err = 0;
        end else if (fl) begin
            model_clear();
        end else begin
            fire = iv && rdy;
            ig   = fire && iwen && ird != 0;
            ic   = fire && icsr;
            rg   = wv && wrd != 0;
            if (rg && m_cnt[wrd] == 0) m_err = 1;
            if (wcsr && m_csr == 0)    m_err = 1;
            if (!(ig && rg && ird == wrd)) begin
                if (ig) m_cnt[ird] = (m_cnt[ird] < MAXP) ? m_cnt[ird] + 1 : MAXP;
                if (rg) m_cnt[wrd] = (m_cnt[wrd] > 0) ? m_cnt[wrd] - 1 : 0;
            end
            if (!(ic && wcsr)) begin
                if (ic)   m_csr = (m_csr < MAXP) ? m_csr + 1 : MAXP;
                if (wcsr) m_csr = (m_csr > 0) ? m_csr - 1 : 0;
            end
        end
        #1;
    endtask

    task automatic idle(input int r1, input int r2);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    task automatic issue_gpr(input int rd);
        step(1, 1, rd, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every presented cycle of outputs is compared against the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp("bubble1",       sb.bubble1,       e.b1);
            cmp("bubble2",       sb.bubble2,       e.b2);
            cmp("bubble3",       sb.bubble3,       e.b3);
            cmp("issue_ready",   sb.issue_ready,   e.rdy);
            cmp("pending_any",   sb.pending_any,   e.pend);
            cmp("err_underflow", sb.err_underflow, e.err);
        end
    end

    initial begin
        int ird, wrd, r1, r2;
        reset = 1'b0;
        sb.issue_valid = 0; sb.issue_rd = 0; sb.issue_wen = 0; sb.issue_csr = 0;
        sb.wb_valid = 0; sb.wb_rd = 0; sb.wb_csr = 0; sb.flush = 0; sb.rs1 = 0; sb.rs2 = 0;
        @(posedge clk);
        #1;
        model_clear();
        m_err = 0;

        // Post-reset state for assorted sources.
        idle(5, 9);
        idle(31, 1);

        // rd=5 hazard and writeback bypass.
        issue_gpr(5);
        idle(5, 0);
        step(1, 0, 0, 0, 0, 1, 5, 0, 0, 5, 0);
        idle(5, 5);

        // rd=7 saturation and same-cycle retire freeing a slot.
        issue_gpr(7); issue_gpr(7); issue_gpr(7);
        step(1, 1, 7, 1, 0, 0, 0, 0, 0, 7, 0);
        step(1, 1, 7, 1, 0, 1, 7, 0, 0, 7, 0);
        idle(7, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 7, 0, 0, 7, 0);
        idle(7, 0);

        // rd=0 is never tracked.
        step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0);

        // CSR hazard, bypass, then underflow.
        step(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(0, 0);
        idle(0, 0);

        // Flush with a simultaneous issue.
        issue_gpr(3); issue_gpr(9);
        step(1, 1, 0, 0, 1, 0, 0, 0, 0, 3, 9);
        step(1, 1, 4, 1, 0, 0, 0, 0, 1, 3, 9);
        idle(4, 3);

        // Reset mid-operation.
        issue_gpr(12);
        idle(12, 0);
        step(0, 1, 12, 1, 0, 0, 0, 0, 0, 12, 0);
        step(1, 1, 12, 1, 0, 0, 0, 0, 0, 12, 0);
        idle(12, 0);

        // Randomized traffic concentrated on a few registers to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            ird = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5);
            wrd = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5);
            r1  = $urandom_range(0, 6);
            r2  = $urandom_range(0, 31);
            step($urandom_range(0, 299) != 0,
                 $urandom_range(0, 9) < 6, ird, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) < 4, wrd, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 39) == 0, r1, r2);
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
